// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and read-latency helper for the BRAM port arbiter
package bram_arb_pkg;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic int read_latency(input int pipelined);
        return 1 + pipelined;
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// bram_resp_fifo: synchronous response FIFO with flags and register-sourced output
module bram_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // storage array, no reset needed since empty masks stale entries
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin two-requester sequencer for one BRAM port with credit-guarded read responses
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WE_WIDTH-1:0]   req0_we,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WE_WIDTH-1:0]   req1_we,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  ram_en,
    output logic [WE_WIDTH-1:0]   ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int LAT = read_latency(PIPELINED);
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    logic [CW-1:0] out0;
    logic [CW-1:0] out1;
    req_id_t       last_grant;
    tag_t          tag_pipe [LAT];
    logic          elig0, elig1, gnt0, gnt1, rd0, rd1;
    logic          push0, push1, pop0, pop1;
    logic          full0, full1, empty0, empty1;

    // a read is only eligible while its response slot is guaranteed
    assign elig0 = !RST && req0_valid && (req0_we != '0 || out0 < CW'(RESP_DEPTH));
    assign elig1 = !RST && req1_valid && (req1_we != '0 || out1 < CW'(RESP_DEPTH));
    assign gnt0  = elig0 && (!elig1 || last_grant == 1'b1);
    assign gnt1  = elig1 && (!elig0 || last_grant == 1'b0);
    assign rd0   = gnt0 && req0_we == '0;
    assign rd1   = gnt1 && req1_we == '0;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign ram_en     = gnt0 || gnt1;
    assign ram_we     = gnt1 ? req1_we : gnt0 ? req0_we : '0;
    assign ram_addr   = gnt1 ? req1_addr : req0_addr;
    assign ram_din    = gnt1 ? req1_data : req0_data;

    assign push0       = tag_pipe[LAT-1].valid && tag_pipe[LAT-1].id == 1'b0 && !full0;
    assign push1       = tag_pipe[LAT-1].valid && tag_pipe[LAT-1].id == 1'b1 && !full1;
    assign resp0_valid = !empty0;
    assign resp1_valid = !empty1;
    assign pop0        = resp0_valid && resp0_ready;
    assign pop1        = resp1_valid && resp1_ready;

    // tag pipe follows each read through the RAM latency to steer its data
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_pipe <= '{default: '0};
        end else begin
            tag_pipe[0] <= tag_t'{rd0 || rd1, gnt1};
            for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // outstanding-read credits and round-robin history
    always_ff @(posedge CLK) begin
        if (RST) begin
            out0       <= '0;
            out1       <= '0;
            last_grant <= 1'b1;
        end else begin
            out0 <= out0 + CW'(rd0) - CW'(pop0);
            out1 <= out1 + CW'(rd1) - CW'(pop1);
            if (ram_en) last_grant <= gnt1;
        end
    end

    bram_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo0 (
        .CLK(CLK), .RST(RST), .push(push0), .din(ram_dout), .pop(pop0),
        .dout(resp0_data), .full(full0), .empty(empty0)
    );

    bram_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo1 (
        .CLK(CLK), .RST(RST), .push(push1), .din(ram_dout), .pop(pop1),
        .dout(resp1_data), .full(full1), .empty(empty1)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: randomized and directed checks of the BRAM port arbiter against a reference model
module tb_bram_port_arbiter;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int WW    = 4;
    localparam int PIPE  = 1;
    localparam int DEPTH = 4;
    localparam int LAT   = 1 + PIPE;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, ram_addr;
    logic [WW-1:0] req0_we, req1_we, ram_we;
    logic [DW-1:0] req0_data, req1_data, ram_din, ram_dout;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready, ram_en;
    logic [DW-1:0] resp0_data, resp1_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    bram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .PIPELINED(PIPE), .RESP_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // distinct contents per word; word 5 holds 0x11223344
    function automatic logic [31:0] init_val(input int i);
        logic [31:0] k;
        k = 32'(i ^ 5);
        return 32'h11223344 ^ (k * 32'h9E3779B1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    // write-first block RAM with 1 or 2 cycle read latency
    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] rq1, rq2;
    assign ram_dout = (PIPE != 0) ? rq2 : rq1;
    initial begin
        logic [DW-1:0] m;
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
        forever begin
            @(posedge CLK);
            if (ram_en) begin
                m = merge(ram[ram_addr], ram_din, ram_we);
                ram[ram_addr] = m;
                rq1 <= m;
            end
            rq2 <= rq1;
        end
    end

    // reference model: per-requester expected-data queues filled in grant order
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    initial begin
        bit            last_g, rst_q, e0, e1, g0, g1;
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        logic [DW-1:0] d;
        last_g = 1'b1;
        rst_q  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge CLK);
            if (RST) begin
                check("rst_ready0", req0_ready, 0);
                check("rst_ready1", req1_ready, 0);
                check("rst_ram_en", ram_en, 0);
                check("rst_ram_we", ram_we, 0);
                if (rst_q) begin
                    check("rst_resp0_valid", resp0_valid, 0);
                    check("rst_resp1_valid", resp1_valid, 0);
                end
                exp0.delete();
                exp1.delete();
                last_g = 1'b1;
            end else begin
                e0 = req0_valid && (req0_we != 0 || exp0.size() < DEPTH);
                e1 = req1_valid && (req1_we != 0 || exp1.size() < DEPTH);
                g0 = e0 && (!e1 || last_g);
                g1 = e1 && (!e0 || !last_g);
                check("ready0", req0_ready, g0);
                check("ready1", req1_ready, g1);
                check("ram_en", ram_en, g0 | g1);
                if (g0 || g1) begin
                    a = g1 ? req1_addr : req0_addr;
                    w = g1 ? req1_we : req0_we;
                    d = g1 ? req1_data : req0_data;
                    check("ram_addr", ram_addr, a);
                    check("ram_we", ram_we, w);
                    check("ram_din", ram_din, d);
                    last_g = g1;
                    if (w != 0) ref_mem[a] = merge(ref_mem[a], d, w);
                    else if (g1) exp1.push_back(ref_mem[a]);
                    else exp0.push_back(ref_mem[a]);
                end else begin
                    check("idle_ram_we", ram_we, 0);
                end
                if (resp0_valid && resp0_ready) begin
                    if (exp0.size() == 0) check("resp0_unexpected", resp0_valid, 0);
                    else check("resp0_data", resp0_data, exp0.pop_front());
                end
                if (resp1_valid && resp1_ready) begin
                    if (exp1.size() == 0) check("resp1_unexpected", resp1_valid, 0);
                    else check("resp1_data", resp1_data, exp1.pop_front());
                end
            end
            rst_q = RST;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int i = 0; i < 50 && (exp0.size() != 0 || exp1.size() != 0); i++) next_cycle();
        next_cycle();
        check("drain0", exp0.size(), 0);
        check("drain1", exp1.size(), 0);
    endtask

    task automatic wait_resp0(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!resp0_valid && cyc < 20);
    endtask

    initial begin
        int cyc, k, g0, g1;
        bit first, acc0, acc1;
        req0_valid = 1'b1; req0_addr = 0; req0_we = 0; req0_data = 0;
        req1_valid = 1'b1; req1_addr = 1; req1_we = 0; req1_data = 0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("first_tie_req0", req0_ready, 1);
        next_cycle();
        @(negedge CLK);
        check("second_tie_req1", req1_ready, 1);
        next_cycle();
        drain();

        // write bytes 0..1 of word 5, then read it back
        req0_valid = 1'b1; req0_addr = 5; req0_we = 4'b0011; req0_data = 32'hAABBCCDD;
        @(negedge CLK);
        check("wr_granted", req0_ready, 1);
        next_cycle();
        req0_we = 4'b0000;
        @(negedge CLK);
        check("rd_granted", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        wait_resp0(cyc);
        check("rd_latency", cyc, LAT + 1);
        check("rd_merged_data", resp0_data, 32'h1122CCDD);
        next_cycle();
        drain();

        // fairness: both requesters read continuously
        g0 = 0; g1 = 0; first = 0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 0; req1_we = 0;
        for (int i = 0; i < 100; i++) begin
            req0_addr = AW'($urandom);
            req1_addr = AW'($urandom);
            @(negedge CLK);
            if (i == 0) first = req0_ready;
            else check("alternate", req0_ready, first ^ i[0]);
            g0 += int'(req0_ready);
            g1 += int'(req1_ready);
            next_cycle();
        end
        check("fair_req0", g0, 50);
        check("fair_req1", g1, 50);
        drain();

        // credit stall on requester 0 while requester 1 keeps flowing
        k = 0; g1 = 0;
        resp0_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req0_valid = k < 6; req0_addr = AW'(10 + k); req0_we = 0;
            req1_valid = 1'b1; req1_addr = AW'($urandom); req1_we = 0;
            @(negedge CLK);
            if (req0_ready) k++;
            g1 += int'(req1_ready);
            next_cycle();
        end
        check("stall_granted", k, 4);
        check("stall_req1_flow", g1, 16);
        resp0_ready = 1'b1;
        req1_valid  = 1'b0;
        for (int i = 0; i < 30 && k < 6; i++) begin
            req0_valid = k < 6; req0_addr = AW'(10 + k);
            @(negedge CLK);
            if (req0_ready) k++;
            next_cycle();
        end
        check("stall_resume", k, 6);
        drain();

        // reset while a read is in flight
        req0_valid = 1'b1; req0_addr = 5; req0_we = 0;
        @(negedge CLK);
        check("mf_granted", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("mf_no_resp", resp0_valid, 0);
            next_cycle();
        end
        req0_valid = 1'b1;
        @(negedge CLK);
        check("mf_regranted", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        wait_resp0(cyc);
        check("mf_latency", cyc, LAT + 1);
        check("mf_data", resp0_data, 32'h1122CCDD);
        next_cycle();
        drain();

        // random mixed traffic with backpressure; requests held until accepted
        acc0 = 1'b1; acc1 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom % 4) != 0;
                req0_addr  = AW'($urandom % 16);
                req0_we    = ($urandom % 2) ? WW'(0) : WW'($urandom);
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom % 4) != 0;
                req1_addr  = AW'($urandom % 16);
                req1_we    = ($urandom % 2) ? WW'(0) : WW'($urandom);
                req1_data  = $urandom;
            end
            resp0_ready = ($urandom % 3) != 0;
            resp1_ready = ($urandom % 3) != 0;
            @(negedge CLK);
            acc0 = req0_ready;
            acc1 = req1_ready;
            next_cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
